// File: rtl/pred_regfile.sv
// Predicate register file with a one-entry writeback register, writeback bypass
// on both read ports, and a per-register busy scoreboard. p0 is hardwired true.
module pred_regfile #(
  parameter int unsigned NUM_PREGS = 8,
  parameter int unsigned IDX_W     = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ex_valid_i,
  input  logic [IDX_W-1:0] ex_dst_i,
  input  logic             ex_result_i,
  input  logic             flush_i,
  input  logic             iss_alloc_i,
  input  logic [IDX_W-1:0] iss_alloc_dst_i,
  input  logic [IDX_W-1:0] rd_a_idx_i,
  input  logic [IDX_W-1:0] rd_b_idx_i,
  output logic             rd_a_data_o,
  output logic             rd_b_data_o,
  output logic             rd_a_busy_o,
  output logic             rd_b_busy_o,
  output logic             wb_valid_o,
  output logic [IDX_W-1:0] wb_dst_o,
  output logic             wb_result_o
);

  // Bit 0 of each vector is kept at zero; p0 is synthesised as a constant on the read side.
  logic [NUM_PREGS-1:0] preg_q, preg_d;
  logic [NUM_PREGS-1:0] busy_q, busy_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [IDX_W-1:0]     wb_dst_q, wb_dst_d;
  logic                 wb_result_q, wb_result_d;

  always_comb begin
    wb_valid_d  = ex_valid_i & ~flush_i & (ex_dst_i != '0);
    wb_dst_d    = wb_dst_q;
    wb_result_d = wb_result_q;
    if (ex_valid_i) begin
      wb_dst_d    = ex_dst_i;
      wb_result_d = ex_result_i;
    end
  end

  // Commit ignores flush: the wb entry is already past the squash point.
  always_comb begin
    preg_d = preg_q;
    if (wb_valid_q) begin
      preg_d[wb_dst_q] = wb_result_q;
    end
    preg_d[0] = 1'b0;
  end

  // Alloc is applied after the wb clear so a same-index allocation wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_q) begin
      busy_d[wb_dst_q] = 1'b0;
    end
    if (iss_alloc_i && (iss_alloc_dst_i != '0)) begin
      busy_d[iss_alloc_dst_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      preg_q      <= '0;
      busy_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_dst_q    <= '0;
      wb_result_q <= 1'b0;
    end else begin
      preg_q      <= preg_d;
      busy_q      <= busy_d;
      wb_valid_q  <= wb_valid_d;
      wb_dst_q    <= wb_dst_d;
      wb_result_q <= wb_result_d;
    end
  end

  logic [IDX_W-1:0] rd_idx [2];
  logic [1:0]       rd_data;
  logic [1:0]       rd_busy;

  assign rd_idx[0] = rd_a_idx_i;
  assign rd_idx[1] = rd_b_idx_i;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < 2; p++) begin
      if (rd_idx[p] == '0) begin
        rd_data[p] = 1'b1;
        rd_busy[p] = 1'b0;
      end else if (wb_valid_q && (wb_dst_q == rd_idx[p])) begin
        rd_data[p] = wb_result_q;
        rd_busy[p] = 1'b0;
      end else begin
        rd_data[p] = preg_q[rd_idx[p]];
        rd_busy[p] = busy_q[rd_idx[p]];
      end
    end
  end

  assign rd_a_data_o = rd_data[0];
  assign rd_b_data_o = rd_data[1];
  assign rd_a_busy_o = rd_busy[0];
  assign rd_b_busy_o = rd_busy[1];
  assign wb_valid_o  = wb_valid_q;
  assign wb_dst_o    = wb_dst_q;
  assign wb_result_o = wb_result_q;

endmodule

// File: tb/tb_pred_regfile.sv
// Bench for pred_regfile: directed scenarios plus random traffic, all checked
// against a behavioural model of committed values, pending busy set and the in-flight result.
module tb_pred_regfile;

  localparam int unsigned N = 8;

  logic       clk;
  logic       rst_ni;
  logic       ex_valid, ex_result, flush, iss_alloc;
  logic [2:0] ex_dst, iss_alloc_dst, rd_a_idx, rd_b_idx;
  logic       rd_a_data, rd_b_data, rd_a_busy, rd_b_busy;
  logic       wb_valid, wb_result;
  logic [2:0] wb_dst;

  int total = 0;
  int bad   = 0;

  pred_regfile #(.NUM_PREGS(N), .IDX_W(3)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .ex_valid_i      (ex_valid),
    .ex_dst_i        (ex_dst),
    .ex_result_i     (ex_result),
    .flush_i         (flush),
    .iss_alloc_i     (iss_alloc),
    .iss_alloc_dst_i (iss_alloc_dst),
    .rd_a_idx_i      (rd_a_idx),
    .rd_b_idx_i      (rd_b_idx),
    .rd_a_data_o     (rd_a_data),
    .rd_b_data_o     (rd_b_data),
    .rd_a_busy_o     (rd_a_busy),
    .rd_b_busy_o     (rd_b_busy),
    .wb_valid_o      (wb_valid),
    .wb_dst_o        (wb_dst),
    .wb_result_o     (wb_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: architectural values, outstanding allocations, and the one result in flight.
  bit       m_val  [N];
  bit       m_busy [N];
  bit       m_fly;
  bit [2:0] m_fly_dst;
  bit       m_fly_res;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit [1:0] model_rd(input bit [2:0] i);
    if (i == 0) return 2'b10;
    if (m_fly && m_fly_dst == i) return {m_fly_res, 1'b0};
    return {m_val[i], m_busy[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_val[i]  = 1'b0;
      m_busy[i] = 1'b0;
    end
    m_fly     = 1'b0;
    m_fly_dst = 3'd0;
    m_fly_res = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    bit [1:0] ea, eb;
    ea = model_rd(rd_a_idx);
    eb = model_rd(rd_b_idx);
    check({tag, ".rd_a_data"}, {2'b0, rd_a_data}, {2'b0, ea[1]});
    check({tag, ".rd_a_busy"}, {2'b0, rd_a_busy}, {2'b0, ea[0]});
    check({tag, ".rd_b_data"}, {2'b0, rd_b_data}, {2'b0, eb[1]});
    check({tag, ".rd_b_busy"}, {2'b0, rd_b_busy}, {2'b0, eb[0]});
    check({tag, ".wb_valid"}, {2'b0, wb_valid}, {2'b0, m_fly});
    if (m_fly) begin
      check({tag, ".wb_dst"}, wb_dst, m_fly_dst);
      check({tag, ".wb_result"}, {2'b0, wb_result}, {2'b0, m_fly_res});
    end
  endtask

  task automatic step(input string tag, input logic ev, input logic [2:0] ed, input logic er,
                      input logic fl, input logic al, input logic [2:0] ad,
                      input logic [2:0] ra, input logic [2:0] rb);
    @(negedge clk);
    ex_valid = ev; ex_dst = ed; ex_result = er; flush = fl;
    iss_alloc = al; iss_alloc_dst = ad; rd_a_idx = ra; rd_b_idx = rb;
    #1;
    check_outputs(tag);
    // Advance the model across the coming edge.
    if (m_fly) begin
      m_val[m_fly_dst]  = m_fly_res;
      m_busy[m_fly_dst] = 1'b0;
    end
    if (al && ad != 0) m_busy[ad] = 1'b1;
    if (fl) for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    m_fly = ev && !fl && ed != 0;
    if (ev) begin
      m_fly_dst = ed;
      m_fly_res = er;
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    ex_valid = 0; ex_dst = 0; ex_result = 0; flush = 0;
    iss_alloc = 0; iss_alloc_dst = 0; rd_a_idx = 0; rd_b_idx = 1;
    model_reset();
    #12;
    check("reset.p0_data", {2'b0, rd_a_data}, 3'd1);
    check("reset.wb_valid", {2'b0, wb_valid}, 3'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 1; i < N; i += 2) step("reset_rd", 0, 0, 0, 0, 0, 0, 3'(i), 3'(i + 1));

    // Alloc p3, result arrives next cycle, then bypass, then committed.
    step("p3_alloc", 0, 0, 0, 0, 1, 3, 3, 3);
    step("p3_ex", 1, 3, 1, 0, 0, 0, 3, 3);
    check("p3_busy_seen", {2'b0, rd_a_busy}, 3'd1);
    step("p3_bypass", 0, 0, 0, 0, 0, 0, 3, 0);
    check("p3_bypass_data", {2'b0, rd_a_data}, 3'd1);
    step("p3_commit", 0, 0, 0, 0, 0, 0, 3, 3);

    // Same-cycle wb clear and fresh alloc of p5.
    step("p5_alloc", 0, 0, 0, 0, 1, 5, 5, 5);
    step("p5_ex", 1, 5, 1, 0, 0, 0, 5, 5);
    step("p5_realloc", 0, 0, 0, 0, 1, 5, 5, 5);
    step("p5_busy", 0, 0, 0, 0, 0, 0, 5, 5);
    check("p5_busy_again", {2'b0, rd_b_busy}, 3'd1);

    // Flush while p6 is latched in wb and p1/p4 are busy.
    step("fl_alloc1", 0, 0, 0, 0, 1, 1, 1, 4);
    step("fl_alloc4", 1, 6, 1, 0, 1, 4, 1, 4);
    step("fl_flush", 1, 2, 1, 1, 0, 0, 1, 4);
    step("fl_after", 0, 0, 0, 0, 0, 0, 1, 4);
    check("fl_wb_valid", {2'b0, wb_valid}, 3'd0);
    step("fl_vals", 0, 0, 0, 0, 0, 0, 6, 2);
    check("fl_p6_committed", {2'b0, rd_a_data}, 3'd1);
    check("fl_p2_untouched", {2'b0, rd_b_data}, 3'd0);

    // Writes and allocs to p0 are ignored.
    step("p0_ex", 1, 0, 0, 0, 1, 0, 0, 0);
    step("p0_after", 0, 0, 0, 0, 0, 0, 0, 0);
    check("p0_wb_valid", {2'b0, wb_valid}, 3'd0);

    // Back-to-back writes to p7.
    step("p7_w1", 1, 7, 1, 0, 0, 0, 7, 7);
    step("p7_w0", 1, 7, 0, 0, 0, 0, 7, 7);
    step("p7_rd0", 0, 0, 0, 0, 0, 0, 7, 7);
    step("p7_final", 0, 0, 0, 0, 0, 0, 7, 7);
    check("p7_final_val", {2'b0, rd_a_data}, 3'd0);

    for (int c = 0; c < 400; c++) begin
      step("rand", 1'($urandom), 3'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
           1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
    end

    // Mid-operation reset drops the in-flight write and the scoreboard at once.
    step("pre_rst_a", 0, 0, 0, 0, 1, 2, 2, 3);
    step("pre_rst_b", 1, 2, 1, 0, 0, 0, 2, 3);
    @(negedge clk);
    ex_valid = 0; iss_alloc = 0; flush = 0; rd_a_idx = 2; rd_b_idx = 2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 1; i < N; i++) step("post_rst", 0, 0, 0, 0, 0, 0, 3'(i), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
